// File: rtl/activate_diff_pkg.sv
// Shared widths, activation encodings, FSM states and fixed-point constants
// for the activation-derivative unit.
package activate_diff_pkg;

   localparam int SIZE            = 3;
   localparam int DATA_SIZE       = 16;
   localparam int FRAC_BITS       = 8;
   localparam int DENSE_TYPE_SIZE = 4;
   localparam int META_SIZE       = 106;
   localparam int IDX_W           = (SIZE > 1) ? $clog2(SIZE) : 1;

   function automatic int one_of(input int frac);
      return 1 << frac;
   endfunction

   localparam logic signed [DATA_SIZE-1:0] ONE     = DATA_SIZE'(one_of(FRAC_BITS));
   localparam logic signed [DATA_SIZE-1:0] HALF    = DATA_SIZE'(one_of(FRAC_BITS) / 2);
   localparam logic signed [DATA_SIZE-1:0] NEG_ONE = -ONE;

   typedef enum logic [DENSE_TYPE_SIZE-1:0] {
      DENSE_LINEAR  = 4'd0,
      DENSE_RELU    = 4'd1,
      DENSE_SIGMOID = 4'd2,
      DENSE_TANH    = 4'd3
   } dense_type_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_e;

endpackage

// File: rtl/activate_diff_elem.sv
// Combinational single-element activation derivative with one shared multiplier.
// Hard-tanh support is compiled in only when ACTIVATE_DIFF_TANH_EN is defined.
module activate_diff_elem
   import activate_diff_pkg::*;
(
   input  logic [DATA_SIZE-1:0]       i_z,
   input  logic [DENSE_TYPE_SIZE-1:0] i_dense_type,
   output logic [DATA_SIZE-1:0]       o_dz
);

   localparam logic signed [DATA_SIZE+1:0] ONE_X  = {2'b00, ONE};
   localparam logic signed [DATA_SIZE+1:0] HALF_X = {2'b00, HALF};

   logic signed [DATA_SIZE-1:0]   w_z;
   logic signed [DATA_SIZE+1:0]   w_z_x;
   logic signed [DATA_SIZE+1:0]   w_sig_pre;
   logic signed [DATA_SIZE-1:0]   w_s;
   logic signed [DATA_SIZE-1:0]   w_op_a;
   logic signed [DATA_SIZE-1:0]   w_op_b;
   logic signed [2*DATA_SIZE-1:0] w_prod;
   logic signed [2*DATA_SIZE-1:0] w_prod_sh;

   assign w_z       = i_z;
   assign w_z_x     = w_z;
   assign w_sig_pre = (w_z_x >>> 2) + HALF_X;

   // Hard sigmoid s clamped into [0, ONE]
   assign w_s = w_sig_pre[DATA_SIZE+1] ? '0 :
                (w_sig_pre > ONE_X)    ? ONE :
                w_sig_pre[DATA_SIZE-1:0];

`ifdef ACTIVATE_DIFF_TANH_EN
   logic signed [DATA_SIZE-1:0] w_t;
   assign w_t = (w_z > ONE) ? ONE : (w_z < NEG_ONE) ? NEG_ONE : w_z;
`endif

   always_comb begin
      w_op_a = w_s;
      w_op_b = ONE - w_s;
`ifdef ACTIVATE_DIFF_TANH_EN
      if (i_dense_type == DENSE_TANH) begin
         w_op_a = w_t;
         w_op_b = w_t;
      end
`endif
   end

   assign w_prod    = w_op_a * w_op_b;
   assign w_prod_sh = w_prod >>> FRAC_BITS;

   always_comb begin
      o_dz = '0;
      case (i_dense_type)
         DENSE_LINEAR:  o_dz = ONE;
         DENSE_RELU:    o_dz = (!w_z[DATA_SIZE-1] && (w_z != '0)) ? ONE : '0;
         DENSE_SIGMOID: o_dz = w_prod_sh[DATA_SIZE-1:0];
`ifdef ACTIVATE_DIFF_TANH_EN
         DENSE_TANH:    o_dz = ONE - w_prod_sh[DATA_SIZE-1:0];
`endif
         default:       o_dz = '0;
      endcase
   end

endmodule

// File: rtl/activate_diff_unit.sv
// Serial activation-derivative unit: one element per cycle through a shared
// datapath, valid/ready on both sides. Optional macro: ACTIVATE_DIFF_TANH_EN.
module activate_diff_unit
   import activate_diff_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_in_valid,
   output logic                        o_in_ready,
   input  logic [DATA_SIZE*SIZE-1:0]   i_z,
   input  logic [DENSE_TYPE_SIZE-1:0]  i_dense_type,
   input  logic [META_SIZE-1:0]        i_meta_in,
   output logic                        o_out_valid,
   input  logic                        i_out_ready,
   output logic [DATA_SIZE*SIZE-1:0]   o_dz,
   output logic [DATA_SIZE*SIZE-1:0]   o_z_out,
   output logic [META_SIZE-1:0]        o_meta_out
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);

   state_e                      r_state;
   state_e                      w_state_next;
   logic [IDX_W-1:0]            r_idx;
   logic [DATA_SIZE*SIZE-1:0]   r_z;
   logic [DENSE_TYPE_SIZE-1:0]  r_dense_type;
   logic [META_SIZE-1:0]        r_meta;
   logic [DATA_SIZE-1:0]        w_z_sel;
   logic [DATA_SIZE-1:0]        w_dz_elem;
   logic                        w_accept;
   logic                        w_in_ready;

   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (i_in_valid) begin
               w_accept     = 1'b1;
               w_state_next = COMPUTE;
            end
         end
         COMPUTE: begin
            if (r_idx == IDX_LAST) w_state_next = DONE;
         end
         DONE: begin
            if (i_out_ready) begin
               w_in_ready   = 1'b1;
               w_state_next = IDLE;
               if (i_in_valid) begin
                  w_accept     = 1'b1;
                  w_state_next = COMPUTE;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_z          <= '0;
         r_dense_type <= '0;
         r_meta       <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_idx        <= '0;
            r_z          <= i_z;
            r_dense_type <= i_dense_type;
            r_meta       <= i_meta_in;
         end else if (r_state == COMPUTE && r_idx != IDX_LAST) begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   assign w_z_sel = r_z[r_idx*DATA_SIZE +: DATA_SIZE];

   activate_diff_elem u_elem (
      .i_z          (w_z_sel),
      .i_dense_type (r_dense_type),
      .o_dz         (w_dz_elem)
   );

   // Each lane only loads when idx points at it; lanes are not cleared on accept.
   generate
      for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
         logic [DATA_SIZE-1:0] r_dz_lane;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r_dz_lane <= '0;
            else if (r_state == COMPUTE && r_idx == IDX_W'(gi))
               r_dz_lane <= w_dz_elem;
         end
         assign o_dz[gi*DATA_SIZE +: DATA_SIZE] = r_dz_lane;
      end
   endgenerate

   assign o_in_ready  = w_in_ready;
   assign o_out_valid = (r_state == DONE);
   assign o_z_out     = r_z;
   assign o_meta_out  = r_meta;

endmodule
